// File: rtl/mt_init_scrub_mrnrwpw.sv
// Map-table initialise-and-scrub engine.
// After reset it writes an identity map with interleaved parity into every
// row of every t2 copy, then raises ready. In RUN it walks all copies/rows
// with background reads and flags rows whose stored parity no longer
// matches the returned map. Core traffic always wins the t2 read port.
module mt_init_scrub_mrnrwpw #(
  parameter int NUMCOPY    = 3,
  parameter int NUMVROW    = 1024,
  parameter int BITVROW    = 10,
  parameter int NUMPBNK    = 11,
  parameter int BITPBNK    = 4,
  parameter int ECCBITS    = 8,
  parameter int SRAM_DELAY = 1,
  parameter int SCRBGAP    = 16,
  parameter int BITMAPT    = NUMPBNK * BITPBNK,
  parameter int MTWIDTH    = BITMAPT + ECCBITS,
  parameter int BITCOPY    = (NUMCOPY > 1) ? $clog2(NUMCOPY) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       reinit,
  input  logic                       scrub_en,
  input  logic [NUMCOPY-1:0]         core_rd,
  input  logic [NUMCOPY-1:0]         core_wr,
  output logic                       ready,
  output logic [NUMCOPY-1:0]         t2_writeA,
  output logic [NUMCOPY*BITVROW-1:0] t2_addrA,
  output logic [NUMCOPY*MTWIDTH-1:0] t2_dinA,
  output logic [NUMCOPY-1:0]         t2_readB,
  output logic [NUMCOPY*BITVROW-1:0] t2_addrB,
  input  logic [NUMCOPY*MTWIDTH-1:0] t2_doutB,
  output logic                       err_vld,
  output logic [BITCOPY-1:0]         err_copy,
  output logic [BITVROW-1:0]         err_row,
  output logic [15:0]                err_cnt
);

  // Parity bit k covers every map bit j with j mod ECCBITS == k.
  // NOTE: function/comb locals use blocking '='; clocked state uses '<=' only.
  function automatic logic [ECCBITS-1:0] calc_parity(input logic [BITMAPT-1:0] map);
    logic [ECCBITS-1:0] p;
    p = '0;
    for (int k = 0; k < ECCBITS; k++) begin
      for (int j = k; j < BITMAPT; j += ECCBITS) begin
        p[k] = p[k] ^ map[j];
      end
    end
    return p;
  endfunction

  // Identity map: field i holds bank number i.
  function automatic logic [BITMAPT-1:0] ident_map();
    logic [BITMAPT-1:0] m;
    m = '0;
    for (int i = 0; i < NUMPBNK; i++) begin
      m[i*BITPBNK +: BITPBNK] = BITPBNK'(i);
    end
    return m;
  endfunction

  localparam logic [BITMAPT-1:0] IDENT_MAP  = ident_map();
  localparam logic [MTWIDTH-1:0] IDENT_WORD = {calc_parity(IDENT_MAP), IDENT_MAP};

  localparam int GW = $clog2(SCRBGAP + 2);
  localparam int WW = $clog2(SRAM_DELAY + 1);
  localparam logic [GW-1:0]      GAP_LOAD  = GW'(SCRBGAP);
  localparam logic [WW-1:0]      WAIT_LOAD = WW'(SRAM_DELAY);
  localparam logic [BITVROW-1:0] LAST_ROW  = BITVROW'(NUMVROW - 1);
  localparam logic [BITCOPY-1:0] LAST_COPY = BITCOPY'(NUMCOPY - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state;
  logic [BITVROW-1:0] init_row;
  logic [BITCOPY-1:0] scr_copy;
  logic [BITVROW-1:0] scr_row;
  logic [GW-1:0]      gap_cnt;
  logic               pend;
  logic [BITCOPY-1:0] pend_copy;
  logic [BITVROW-1:0] pend_row;
  logic [WW-1:0]      wait_cnt;

  logic [NUMCOPY-1:0] scr_onehot;
  logic [MTWIDTH-1:0] chk_word;
  logic               chk_now;
  logic               chk_fail;
  logic               issue_ok;

  // Core writes need no arbitration here; they only matter to the core.
  logic core_wr_unused;
  assign core_wr_unused = ^core_wr;

  // Decode the scrub target copy and select the returning read data.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    scr_onehot = '0;
    chk_word   = '0;
    for (int c = 0; c < NUMCOPY; c++) begin
      if (scr_copy == BITCOPY'(c)) scr_onehot[c] = 1'b1;
      if (pend_copy == BITCOPY'(c)) chk_word = t2_doutB[c*MTWIDTH +: MTWIDTH];
    end
  end

  assign chk_now  = pend && (wait_cnt == '0);
  assign chk_fail = calc_parity(chk_word[BITMAPT-1:0]) != chk_word[MTWIDTH-1:BITMAPT];
  // A new read may go out in the same cycle the previous one is checked.
  assign issue_ok = (gap_cnt == '0) && scrub_en && ((core_rd & scr_onehot) == '0)
                    && (!pend || chk_now);

  // Engine FSM: identity-map writer, then scrub issue/check with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_INIT;
      init_row  <= '0;
      scr_copy  <= '0;
      scr_row   <= '0;
      gap_cnt   <= GAP_LOAD;
      pend      <= 1'b0;
      pend_copy <= '0;
      pend_row  <= '0;
      wait_cnt  <= '0;
      ready     <= 1'b0;
      t2_writeA <= '0;
      t2_addrA  <= '0;
      t2_dinA   <= '0;
      t2_readB  <= '0;
      t2_addrB  <= '0;
      err_vld   <= 1'b0;
      err_copy  <= '0;
      err_row   <= '0;
      err_cnt   <= '0;
    end else begin
      t2_writeA <= '0;
      t2_readB  <= '0;
      err_vld   <= 1'b0;
      unique case (state)
        ST_INIT: begin
          ready     <= 1'b0;
          t2_writeA <= '1;
          t2_addrA  <= {NUMCOPY{init_row}};
          t2_dinA   <= {NUMCOPY{IDENT_WORD}};
          if (init_row == LAST_ROW) begin
            init_row <= '0;
            state    <= ST_RUN;
          end else begin
            init_row <= init_row + 1'b1;
          end
        end
        ST_RUN: begin
          if (reinit) begin
            // Restart the rewrite; an in-flight check is dropped, err_cnt survives.
            state    <= ST_INIT;
            ready    <= 1'b0;
            init_row <= '0;
            scr_copy <= '0;
            scr_row  <= '0;
            gap_cnt  <= GAP_LOAD;
            pend     <= 1'b0;
            wait_cnt <= '0;
          end else begin
            ready <= 1'b1;
            if (chk_now) begin
              pend <= 1'b0;
              if (chk_fail) begin
                err_vld  <= 1'b1;
                err_copy <= pend_copy;
                err_row  <= pend_row;
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
              end
            end else if (pend) begin
              wait_cnt <= wait_cnt - 1'b1;
            end
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - 1'b1;
            end else if (issue_ok) begin
              for (int c = 0; c < NUMCOPY; c++) begin
                if (scr_copy == BITCOPY'(c)) begin
                  t2_readB[c]                    <= 1'b1;
                  t2_addrB[c*BITVROW +: BITVROW] <= scr_row;
                end
              end
              pend      <= 1'b1;
              pend_copy <= scr_copy;
              pend_row  <= scr_row;
              wait_cnt  <= WAIT_LOAD;
              gap_cnt   <= GAP_LOAD;
              if (scr_copy == LAST_COPY) begin
                scr_copy <= '0;
                scr_row  <= (scr_row == LAST_ROW) ? '0 : scr_row + 1'b1;
              end else begin
                scr_copy <= scr_copy + 1'b1;
              end
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mt_init_scrub_mrnrwpw.sv
// Bench for mt_init_scrub_mrnrwpw: 3 copies x 8 rows, back-to-back scrub,
// a negedge memory model for the t2 ports, and event logs for reads/errors.
module tb_mt_init_scrub_mrnrwpw;
  localparam int NC = 3;
  localparam int NR = 8;
  localparam int BR = 3;
  localparam int MW = 52;
  localparam int BC = 2;
  // Identity map 0xA9876543210; parity = XOR of its bytes = 0x92.
  localparam logic [MW-1:0] ID_WORD = 52'h92A9876543210;

  logic              clk, rst, reinit, scrub_en;
  logic [NC-1:0]     core_rd, core_wr;
  logic              ready;
  logic [NC-1:0]     t2_writeA, t2_readB;
  logic [NC*BR-1:0]  t2_addrA, t2_addrB;
  logic [NC*MW-1:0]  t2_dinA, t2_doutB;
  logic              err_vld;
  logic [BC-1:0]     err_copy;
  logic [BR-1:0]     err_row;
  logic [15:0]       err_cnt;

  mt_init_scrub_mrnrwpw #(
    .NUMCOPY(NC), .NUMVROW(NR), .BITVROW(BR), .SCRBGAP(0), .SRAM_DELAY(1)
  ) dut (
    .clk(clk), .rst(rst), .reinit(reinit), .scrub_en(scrub_en),
    .core_rd(core_rd), .core_wr(core_wr), .ready(ready),
    .t2_writeA(t2_writeA), .t2_addrA(t2_addrA), .t2_dinA(t2_dinA),
    .t2_readB(t2_readB), .t2_addrB(t2_addrB), .t2_doutB(t2_doutB),
    .err_vld(err_vld), .err_copy(err_copy), .err_row(err_row), .err_cnt(err_cnt)
  );

  typedef struct {
    logic       scrub_en;
    logic       reinit;
    logic [2:0] core_rd;
    logic [2:0] ex_wr;
    logic [2:0] ex_row;
    logic       ex_ready;
    logic [2:0] ex_rd;
  } vec_t;

  typedef struct {
    int          copy;
    int          row;
    int          cyc;
    logic [15:0] cnt;
  } ev_t;

  vec_t        vt [11];
  ev_t         rd_q [$];
  ev_t         er_q [$];
  logic [MW-1:0] mem [NC][NR];
  int          cyc;
  int          tests = 0;
  int          fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number: count of rising edges since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // t2 memory model (1-cycle read latency) plus read/error event logging.
  always @(negedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (t2_writeA[c]) mem[c][t2_addrA[c*BR +: BR]] = t2_dinA[c*MW +: MW];
      if (t2_readB[c]) begin
        ev_t e;
        t2_doutB[c*MW +: MW] <= mem[c][t2_addrB[c*BR +: BR]];
        e.copy = c;
        e.row  = int'(t2_addrB[c*BR +: BR]);
        e.cyc  = cyc;
        e.cnt  = 16'h0;
        rd_q.push_back(e);
      end
    end
    if (err_vld) begin
      ev_t e;
      e.copy = int'(err_copy);
      e.row  = int'(err_row);
      e.cyc  = cyc;
      e.cnt  = err_cnt;
      er_q.push_back(e);
    end
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ready"},    ready,     0);
    check({tag, " writeA"},   t2_writeA, 0);
    check({tag, " addrA"},    t2_addrA,  0);
    check({tag, " dinA"},     t2_dinA,   0);
    check({tag, " readB"},    t2_readB,  0);
    check({tag, " addrB"},    t2_addrB,  0);
    check({tag, " err_vld"},  err_vld,   0);
    check({tag, " err_copy"}, err_copy,  0);
    check({tag, " err_row"},  err_row,   0);
    check({tag, " err_cnt"},  err_cnt,   0);
  endtask

  // Apply the init vector table starting from the edge after reset release.
  task automatic run_init_table(input string tag);
    for (int i = 0; i < 11; i++) begin
      scrub_en = vt[i].scrub_en;
      reinit   = vt[i].reinit;
      core_rd  = vt[i].core_rd;
      @(posedge clk); #1;
      check($sformatf("%s c%0d writeA", tag, i+1), t2_writeA, vt[i].ex_wr);
      if (vt[i].ex_wr != 3'b000) begin
        check($sformatf("%s c%0d addrA", tag, i+1), t2_addrA, {NC{vt[i].ex_row}});
        check($sformatf("%s c%0d dinA", tag, i+1), t2_dinA, {NC{ID_WORD}});
      end
      check($sformatf("%s c%0d ready", tag, i+1), ready, vt[i].ex_ready);
      check($sformatf("%s c%0d readB", tag, i+1), t2_readB, vt[i].ex_rd);
      if (vt[i].ex_rd != 3'b000)
        check($sformatf("%s c%0d addrB", tag, i+1), t2_addrB, 0);
      check($sformatf("%s c%0d err_vld", tag, i+1), err_vld, 0);
    end
    reinit  = 1'b0;
    core_rd = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n_err, rc, base;
    logic [BR-1:0] rowb, rown;
    logic found;

    rst = 1'b0; reinit = 1'b0; scrub_en = 1'b0; core_rd = '0; core_wr = '0;
    t2_doutB = '0;

    // Init table: cycles 1..8 write rows 0..7, ready at 9, first reads at 9 and 11.
    // reinit (cycle 4) and core_rd (cycles 1..8) land in INIT and must be ignored.
    for (int i = 0; i < 11; i++) begin
      vt[i].scrub_en = 1'b1;
      vt[i].reinit   = (i == 3);
      vt[i].core_rd  = (i < 8) ? 3'b111 : 3'b000;
      vt[i].ex_wr    = (i < 8) ? 3'b111 : 3'b000;
      vt[i].ex_row   = 3'(i);
      vt[i].ex_ready = (i >= 8);
      vt[i].ex_rd    = (i == 8) ? 3'b001 : (i == 10) ? 3'b010 : 3'b000;
    end

    // Reset state, then release and run the init table.
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    core_wr = 3'b101;
    run_init_table("init");

    // Clean sweep: order c0r0,c1r0,c2r0,c0r1,... wrapping to c0r0 after c2r7.
    for (int i = 0; i < 200 && rd_q.size() < 25; i++) @(posedge clk);
    #1;
    check("sweep read count", (rd_q.size() >= 25), 1);
    if (rd_q.size() >= 25) begin
      for (int i = 0; i < 25; i++)
        check($sformatf("sweep read %0d copy/row", i),
              rd_q[i].copy * 16 + rd_q[i].row, (i % 3) * 16 + (i / 3) % 8);
      check("sweep spacing", rd_q[24].cyc - rd_q[0].cyc, 48);
    end
    check("sweep no errors", er_q.size(), 0);

    // Corrupt map bit 5 of copy 1 row 3.
    mem[1][3] = mem[1][3] ^ (52'd1 << 5);
    for (int i = 0; i < 200 && er_q.size() < 1; i++) @(posedge clk);
    #1;
    check("corrupt err seen", (er_q.size() >= 1), 1);
    if (er_q.size() >= 1) begin
      check("corrupt err_copy", er_q[0].copy, 1);
      check("corrupt err_row", er_q[0].row, 3);
      check("corrupt err_cnt", er_q[0].cnt, 1);
      rc = -1000;
      foreach (rd_q[i]) if (rd_q[i].copy == 1 && rd_q[i].row == 3 && rd_q[i].cyc < er_q[0].cyc) rc = rd_q[i].cyc;
      check("corrupt err latency", er_q[0].cyc - rc, 2);
    end
    for (int i = 0; i < 200 && er_q.size() < 2; i++) @(posedge clk);
    #1;
    check("repeat err seen", (er_q.size() >= 2), 1);
    if (er_q.size() >= 2) begin
      check("repeat err_cnt", er_q[1].cnt, 2);
      check("repeat err row", er_q[1].copy * 16 + er_q[1].row, 1 * 16 + 3);
      check("repeat err period", er_q[1].cyc - er_q[0].cyc, 48);
    end

    // Saturation: preload the counter just below the limit.
    force dut.err_cnt = 16'hFFFE;
    #1;
    release dut.err_cnt;
    for (int i = 0; i < 200 && er_q.size() < 4; i++) @(posedge clk);
    #1;
    check("sat err seen", (er_q.size() >= 4), 1);
    if (er_q.size() >= 4) begin
      check("sat reaches max", er_q[2].cnt, 16'hFFFF);
      check("sat holds max", er_q[3].cnt, 16'hFFFF);
    end

    // core_rd[0] held for 4 cycles across the copy-0 issue point.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      found = t2_readB[2];
    end
    check("block find copy2 read", found, 1);
    rowb = t2_addrB[2*BR +: BR];
    rown = rowb + 3'd1;
    core_rd = 3'b001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("block cycle %0d readB", i), t2_readB, 0);
    end
    core_rd = '0;
    @(posedge clk); #1;
    check("block release readB", t2_readB, 3'b001);
    check("block release row", t2_addrB[0 +: BR], rown);
    @(posedge clk); @(posedge clk); #1;
    check("block order next", t2_readB, 3'b010);
    check("block order row", t2_addrB[BR +: BR], rown);

    // reinit while the corrupted row's read is outstanding.
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(posedge clk); #1;
      found = t2_readB[1] && (t2_addrB[BR +: BR] == 3'd3);
    end
    check("reinit find c1r3 read", found, 1);
    n_err = er_q.size();
    reinit = 1'b1;
    @(posedge clk); #1;
    reinit = 1'b0;
    check("reinit ready drop", ready, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("reinit write %0d", i), {t2_writeA, t2_readB, t2_addrA}, {3'b111, 3'b000, {NC{3'(i)}}});
    end
    @(posedge clk); #1;
    check("reinit ready back", ready, 1);
    check("reinit first read", {t2_readB, t2_addrB[0 +: BR]}, {3'b001, 3'd0});
    check("reinit no err pulse", er_q.size(), n_err);
    check("reinit err_cnt kept", err_cnt, 16'hFFFF);
    base = rd_q.size();
    for (int i = 0; i < 200 && rd_q.size() < base + 25; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("rewrite cleans row", er_q.size(), n_err);

    // Reset asserted mid-INIT at row 4.
    reinit = 1'b1;
    @(posedge clk); #1;
    reinit = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge clk); #1;
      found = t2_writeA[0] && (t2_addrA[0 +: BR] == 3'd4);
    end
    check("midinit find row4", found, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("async reset");
    @(negedge clk);
    rst = 1'b1;
    run_init_table("post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
